// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// A three-state FSM (IDLE/CALC/DONE) captures operands on start, spends exactly
// WIDTH cycles adding shifted copies of the multiplicand, then presents the
// product on Z together with a one-cycle done pulse.
module shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   X,
   input  logic [WIDTH-1:0]   Y,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] Z
);

   // Counter must be able to represent WIDTH itself, hence WIDTH+1.
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state_q;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   acc_d;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   z_q;

   // Partial-product add for the current multiplier bit.
   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
   end

   // FSM plus datapath registers; reset wins over everything, including start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         z_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q  <= {{WIDTH{1'b0}}, X};
                  mplier_q <= Y;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= CALC;
               end
            end
            CALC: begin
               // start and X/Y are deliberately not looked at here.
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  z_q     <= acc_d;
                  state_q <= DONE;
               end
            end
            DONE: begin
               // Back-to-back: a start seen in DONE skips the IDLE bubble.
               if (start) begin
                  mcand_q  <= {{WIDTH{1'b0}}, X};
                  mplier_q <= Y;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= CALC;
               end else begin
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = (state_q == CALC);
   assign done = (state_q == DONE);
   assign Z    = z_q;

endmodule
